point_fetch_unit: RTL and testbench
===================================

Name: point_fetch_unit

Overview:
- Synthesizable upstream stage for Controller; replaces bench-side BRAM fetch logic.
- Reads packed point words (PPW = BUS_SIZE/N points per word) from three single-port x/y/z BRAMs with 1-cycle read latency.
- Builds the CORE_NUMBER-point core cache whenever Controller raises update_cache.
- Otherwise streams the cloud into the DISTANCE_MODULES-point feeder cache, batch by batch, with wrap-around.

Parameters:
- N, 16, bits per coordinate.
- BUS_SIZE, 32, BRAM word width; PPW = BUS_SIZE/N; must divide CORE_NUMBER and DISTANCE_MODULES.
- CORE_NUMBER, 4, core cache points.
- DISTANCE_MODULES, 2, feeder cache points per batch.
- ADDR_W, 16, BRAM word-address width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- point_cloud_size  in  2N  number of valid points; stable while operating.
- start  in  1  one-cycle pulse; begins operation from IDLE.
- update_cache  in  1  level from Controller; requests a core refill.
- point_pos  in  2N  1-based position from Controller; first core point index = point_pos-1.
- controller_done  in  1  forces return to IDLE.
- bram_addr  out  ADDR_W  shared word address for x/y/z.
- bram_en  out  1  read enable.
- rdata_x/rdata_y/rdata_z  in  BUS_SIZE  word data, valid the cycle after bram_en.
- cache_x/cache_y/cache_z  out  N*CORE_NUMBER  core cache; slot s at bits [s*N +: N].
- cache_feeder_x/y/z  out  N*DISTANCE_MODULES  feeder batch; slot s at bits [s*N +: N].
- cache_updated  out  1  one-cycle pulse: core cache complete.
- pause  out  1  low for exactly one cycle when a feeder batch is valid.
- busy  out  1  high outside IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - All caches 0; bram_addr 0; bram_en 0; cache_updated 0; pause 1; busy 0.
  - Feeder word pointer fptr 0; state IDLE.
  - Reset mid-fill discards partial data, with no cache_updated pulse.
- Point addressing: point index i lives in word i/PPW, lane i%PPW, bits [lane*N +: N] of rdata.
  - Last word: LW = ceil(point_cloud_size/PPW)-1.
- States: IDLE, CORE_RD, CORE_DONE, FEED_RD, FEED_OUT.
- IDLE:
  - start=1 -> CORE_RD if update_cache=1, else FEED_RD.
- CORE_RD:
  - Latch i0 = point_pos-1 on entry.
  - Issue words i0/PPW .. (i0+CORE_NUMBER-1)/PPW on consecutive cycles.
  - Each returning word places lane L into slot (word*PPW+L-i0) only if 0 <= slot < CORE_NUMBER.
  - Slots whose index is >= point_cloud_size are written 0 (no wrap for core).
  - Clear cache_x/y/z on entry.
  - After the last data beat -> CORE_DONE.
- CORE_DONE: cache_updated=1 for one cycle -> FEED_RD.
  - Latency: word count W = (i0+CORE_NUMBER-1)/PPW - i0/PPW + 1; cache_updated asserts W+2 cycles after CORE_RD entry.
- FEED_RD:
  - Clear cache_feeder on entry.
  - Issue DISTANCE_MODULES/PPW words from fptr, incrementing fptr each issue; after issuing LW, fptr wraps to 0.
  - Lanes of word LW beyond point_cloud_size-1 load 0.
  - Word k of the batch fills slots [k*PPW, (k+1)*PPW).
  - After the final data beat -> FEED_OUT.
- FEED_OUT: pause=0 for one cycle, feeder valid.
  - Then priority: controller_done -> IDLE; update_cache -> CORE_RD; else FEED_RD.
- update_cache arbitration:
  - Sampled only at batch boundaries (FEED_OUT) and in IDLE on start.
  - A batch in flight always completes; fptr is preserved across core refills.
- controller_done in any state -> IDLE next cycle. Caches hold; no pulse; fptr kept (cleared only by reset or start).
- bram_en is high only on issue cycles; bram_addr holds its last value otherwise.
- cache_x/y/z hold between refills; cache_feeder holds until the next FEED_RD entry.

Decomposition:
- Shared package pfu_pkg:
  - state enum.
  - PPW constant.
  - Function word_of(i) and function lane_of(i).
  - Function last_word(size).
- One sub-module: point_lane_unpack. Combinational: given a word, its word index, a base point index and size, it outputs per-slot N-bit values and write-enable masks.
- Instantiated once for core and once for feeder (CORE_NUMBER vs DISTANCE_MODULES slots); the same module serves x/y/z via a generate loop of 3.

Test Plan:
- Aligned core fill: x word w = {16'(2w+1), 16'(2w)}, point_pos=1, update_cache=1, start -> words 0,1 read; cache_x = {3,2,1,0}; cache_updated 4 cycles after CORE_RD entry.
- Misaligned core fill: point_pos=2 (i0=1) -> words 0,1,2 read; cache_x = {4,3,2,1}; cache_updated at W+2=5 cycles.
- Core near end: size=5, point_pos=4 (i0=3) -> cache_x = {0,0,4,3}; slots 2,3 zero.
- Feeder wrap: size=5, update_cache=0 -> batches {1,0}, {3,2}, {0,4}, {1,0}; pause low exactly once per batch.
- Preemption: raise update_cache while batch 2 (fptr=1) is in flight -> batch 2 completes ({3,2}), then core fill; next feeder batch is {0,4}.
- Async reset mid CORE_RD -> outputs at reset values immediately; no cache_updated; idle until start.

Source files
------------

// File: rtl/pfu_pkg.sv
// Shared constants, state encoding and point/word addressing helpers for the
// point fetch unit.
package pfu_pkg;
   localparam int N                = 16;
   localparam int BUS_SIZE         = 32;
   localparam int CORE_NUMBER      = 4;
   localparam int DISTANCE_MODULES = 2;
   localparam int ADDR_W           = 16;
   localparam int PPW              = BUS_SIZE / N;
   localparam int IDX_W            = 2 * N;
   localparam int FEED_WORDS       = DISTANCE_MODULES / PPW;

   typedef enum logic [2:0] {
      IDLE, CORE_RD, CORE_DONE, FEED_RD, FEED_OUT
   } pfu_state_e;

   function automatic logic [IDX_W-1:0] word_of(input logic [IDX_W-1:0] i);
      return i / IDX_W'(PPW);
   endfunction

   function automatic logic [IDX_W-1:0] lane_of(input logic [IDX_W-1:0] i);
      return i % IDX_W'(PPW);
   endfunction

   function automatic logic [IDX_W-1:0] last_word(input logic [IDX_W-1:0] size);
      return (size + IDX_W'(PPW - 1)) / IDX_W'(PPW) - IDX_W'(1);
   endfunction

   function automatic logic [IDX_W-1:0] core_words(input logic [IDX_W-1:0] i0);
      return word_of(i0 + IDX_W'(CORE_NUMBER - 1)) - word_of(i0) + IDX_W'(1);
   endfunction
endpackage

// File: rtl/point_lane_unpack.sv
// Maps the lanes of one BRAM word onto cache slots: slot s holds point base+s;
// points at or beyond size read as zero.
module point_lane_unpack import pfu_pkg::*; #(
   parameter int SLOTS = 4
) (
   input  logic [BUS_SIZE-1:0] word,
   input  logic [IDX_W-1:0]    word_idx,
   input  logic [IDX_W-1:0]    base,
   input  logic [IDX_W-1:0]    size,
   output logic [SLOTS*N-1:0]  vals,
   output logic [SLOTS-1:0]    we
);
   logic [IDX_W-1:0] p;

   always_comb begin
      vals = '0;
      we   = '0;
      p    = '0;
      for (int s = 0; s < SLOTS; s++) begin
         p = base + IDX_W'(s);
         if (word_of(p) == word_idx) begin
            we[s] = 1'b1;
            for (int l = 0; l < PPW; l++) begin
               if (lane_of(p) == IDX_W'(l) && p < size) vals[s*N +: N] = word[l*N +: N];
            end
         end
      end
   end
endmodule

// File: rtl/point_fetch_unit.sv
// Fetches packed points from x/y/z BRAMs into the core cache (on request) or
// streams them batch by batch into the feeder cache with wrap-around.
module point_fetch_unit import pfu_pkg::*; (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [IDX_W-1:0]              point_cloud_size,
   input  logic                          start,
   input  logic                          update_cache,
   input  logic [IDX_W-1:0]              point_pos,
   input  logic                          controller_done,
   output logic [ADDR_W-1:0]             bram_addr,
   output logic                          bram_en,
   input  logic [BUS_SIZE-1:0]           rdata_x,
   input  logic [BUS_SIZE-1:0]           rdata_y,
   input  logic [BUS_SIZE-1:0]           rdata_z,
   output logic [N*CORE_NUMBER-1:0]      cache_x,
   output logic [N*CORE_NUMBER-1:0]      cache_y,
   output logic [N*CORE_NUMBER-1:0]      cache_z,
   output logic [N*DISTANCE_MODULES-1:0] cache_feeder_x,
   output logic [N*DISTANCE_MODULES-1:0] cache_feeder_y,
   output logic [N*DISTANCE_MODULES-1:0] cache_feeder_z,
   output logic                          cache_updated,
   output logic                          pause,
   output logic                          busy,
   output pfu_state_e                    fsm_state
);
   pfu_state_e state, next_state;

   logic [IDX_W-1:0]  i0, core_iss, first_idx, rword_idx, feed_base;
   logic [ADDR_W-1:0] fptr, rword, beat_k, iss_left, lw;
   logic              rvalid, last_beat, enter_core, enter_feed;

   logic [BUS_SIZE-1:0]           rdata    [3];
   logic [N*CORE_NUMBER-1:0]      core_q   [3];
   logic [N*CORE_NUMBER-1:0]      core_val [3];
   logic [CORE_NUMBER-1:0]        core_we  [3];
   logic [N*DISTANCE_MODULES-1:0] feed_q   [3];
   logic [N*DISTANCE_MODULES-1:0] feed_val [3];
   logic [DISTANCE_MODULES-1:0]   feed_we  [3];

   assign rdata[0]   = rdata_x;
   assign rdata[1]   = rdata_y;
   assign rdata[2]   = rdata_z;
   assign first_idx  = point_pos - IDX_W'(1);
   assign lw         = ADDR_W'(last_word(point_cloud_size));
   assign rword_idx  = IDX_W'(rword);
   // Slot 0 of the batch corresponds to the first lane of the batch's first word.
   assign feed_base  = (rword_idx - IDX_W'(beat_k)) * IDX_W'(PPW);
   // Issues are back to back, so the first beat without a following issue is the last.
   assign last_beat  = rvalid && !bram_en;
   assign enter_core = (next_state == CORE_RD) && (state != CORE_RD);
   assign enter_feed = (next_state == FEED_RD) && (state != FEED_RD);

   for (genvar c = 0; c < 3; c++) begin : g_axis
      point_lane_unpack #(.SLOTS(CORE_NUMBER)) u_core (
         .word(rdata[c]), .word_idx(rword_idx), .base(i0), .size(point_cloud_size),
         .vals(core_val[c]), .we(core_we[c])
      );
      point_lane_unpack #(.SLOTS(DISTANCE_MODULES)) u_feed (
         .word(rdata[c]), .word_idx(rword_idx), .base(feed_base), .size(point_cloud_size),
         .vals(feed_val[c]), .we(feed_we[c])
      );
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (controller_done) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:      if (start) next_state = update_cache ? CORE_RD : FEED_RD;
            CORE_RD:   if (last_beat) next_state = CORE_DONE;
            CORE_DONE: next_state = FEED_RD;
            FEED_RD:   if (last_beat) next_state = FEED_OUT;
            FEED_OUT:  next_state = update_cache ? CORE_RD : FEED_RD;
            default:   next_state = IDLE;
         endcase
      end
   end

   always_comb begin
      busy          = (state != IDLE);
      cache_updated = (state == CORE_DONE);
      pause         = (state != FEED_OUT);
      fsm_state     = state;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bram_addr <= '0;
         bram_en   <= 1'b0;
         rvalid    <= 1'b0;
         rword     <= '0;
         fptr      <= '0;
         beat_k    <= '0;
         iss_left  <= '0;
         i0        <= '0;
         core_iss  <= '0;
         for (int c = 0; c < 3; c++) begin
            core_q[c] <= '0;
            feed_q[c] <= '0;
         end
      end else begin
         rvalid  <= bram_en;
         rword   <= bram_addr;
         bram_en <= 1'b0;
         if (state == IDLE && start) fptr <= '0;
         if (enter_core) begin
            i0       <= first_idx;
            core_iss <= word_of(first_idx);
            iss_left <= ADDR_W'(core_words(first_idx));
            for (int c = 0; c < 3; c++) core_q[c] <= '0;
         end else if (enter_feed) begin
            iss_left <= ADDR_W'(FEED_WORDS);
            beat_k   <= '0;
            for (int c = 0; c < 3; c++) feed_q[c] <= '0;
         end else if (iss_left != '0 && !controller_done &&
                      (state == CORE_RD || state == FEED_RD)) begin
            bram_en  <= 1'b1;
            iss_left <= iss_left - 1'b1;
            if (state == CORE_RD) begin
               bram_addr <= core_iss[ADDR_W-1:0];
               core_iss  <= core_iss + 1'b1;
            end else begin
               bram_addr <= fptr;
               fptr      <= (fptr == lw) ? '0 : fptr + 1'b1;
            end
         end
         if (rvalid && state == CORE_RD) begin
            for (int c = 0; c < 3; c++)
               for (int s = 0; s < CORE_NUMBER; s++)
                  if (core_we[c][s]) core_q[c][s*N +: N] <= core_val[c][s*N +: N];
         end
         if (rvalid && state == FEED_RD) begin
            beat_k <= beat_k + 1'b1;
            for (int c = 0; c < 3; c++)
               for (int s = 0; s < DISTANCE_MODULES; s++)
                  if (feed_we[c][s]) feed_q[c][s*N +: N] <= feed_val[c][s*N +: N];
         end
      end
   end

   assign cache_x        = core_q[0];
   assign cache_y        = core_q[1];
   assign cache_z        = core_q[2];
   assign cache_feeder_x = feed_q[0];
   assign cache_feeder_y = feed_q[1];
   assign cache_feeder_z = feed_q[2];
endmodule

// File: tb/tb_point_fetch_unit.sv
// Directed bench for point_fetch_unit: BRAM model with read log, hand-computed
// cache contents and pulse timing checked with immediate assertions.
module tb_point_fetch_unit;
   import pfu_pkg::*;

   logic                          clock = 1'b0;
   logic                          reset;
   logic [IDX_W-1:0]              point_cloud_size;
   logic                          start, update_cache, controller_done;
   logic [IDX_W-1:0]              point_pos;
   logic [ADDR_W-1:0]             bram_addr;
   logic                          bram_en;
   logic [BUS_SIZE-1:0]           rdata_x = '0, rdata_y = '0, rdata_z = '0;
   logic [N*CORE_NUMBER-1:0]      cache_x, cache_y, cache_z;
   logic [N*DISTANCE_MODULES-1:0] cache_feeder_x, cache_feeder_y, cache_feeder_z;
   logic                          cache_updated, pause, busy;
   pfu_state_e                    fsm_state;

   logic [BUS_SIZE-1:0] mem_x [16];
   logic [BUS_SIZE-1:0] mem_y [16];
   logic [BUS_SIZE-1:0] mem_z [16];
   logic [ADDR_W-1:0]   log_q [$];
   int                  exp_log [$];
   int                  n_assert = 0;
   int                  n_fail = 0;
   int                  n;

   logic [31:0] exp_fx [4] = '{32'h0001_0000, 32'h0003_0002, 32'h0000_0004, 32'h0001_0000};
   logic [31:0] exp_fy [4] = '{32'h0101_0100, 32'h0103_0102, 32'h0000_0104, 32'h0101_0100};

   point_fetch_unit dut (
      .clock(clock), .reset(reset), .point_cloud_size(point_cloud_size), .start(start),
      .update_cache(update_cache), .point_pos(point_pos), .controller_done(controller_done),
      .bram_addr(bram_addr), .bram_en(bram_en),
      .rdata_x(rdata_x), .rdata_y(rdata_y), .rdata_z(rdata_z),
      .cache_x(cache_x), .cache_y(cache_y), .cache_z(cache_z),
      .cache_feeder_x(cache_feeder_x), .cache_feeder_y(cache_feeder_y),
      .cache_feeder_z(cache_feeder_z), .cache_updated(cache_updated),
      .pause(pause), .busy(busy), .fsm_state(fsm_state)
   );

   always #5 clock = ~clock;

   // Single-port BRAMs with one-cycle read latency, plus a log of issued addresses.
   always @(posedge clock) begin
      if (bram_en) begin
         rdata_x <= mem_x[bram_addr[3:0]];
         rdata_y <= mem_y[bram_addr[3:0]];
         rdata_z <= mem_z[bram_addr[3:0]];
         log_q.push_back(bram_addr);
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_log(input string tag);
      check({tag, "_len"}, 64'(log_q.size()), 64'(exp_log.size()));
      for (int i = 0; i < exp_log.size() && i < log_q.size(); i++)
         check(tag, 64'(log_q[i]), 64'(exp_log[i]));
   endtask

   task automatic start_op();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   // sel 0: wait for pause low; sel 1: wait for cache_updated. Bounded at 20 cycles.
   task automatic wait_for(input int sel, output int cnt);
      cnt = 0;
      while (!((sel == 0) ? (pause == 1'b0) : (cache_updated == 1'b1)) && cnt < 20) begin
         @(negedge clock);
         cnt++;
      end
   endtask

   task automatic stop_op();
      controller_done = 1'b1;
      @(negedge clock);
      controller_done = 1'b0;
   endtask

   initial begin
      for (int w = 0; w < 16; w++) begin
         mem_x[w] = {16'(2*w + 1), 16'(2*w)};
         mem_y[w] = {16'(2*w + 1 + 256), 16'(2*w + 256)};
         mem_z[w] = {16'(2*w + 1 + 512), 16'(2*w + 512)};
      end
      reset = 1'b0; start = 1'b0; update_cache = 1'b0; controller_done = 1'b0;
      point_cloud_size = 32'd8; point_pos = 32'd1;
      #1;
      check("rst_cache_x", cache_x, 64'h0);
      check("rst_feeder_x", cache_feeder_x, 64'h0);
      check("rst_bram", {bram_en, bram_addr}, 64'h0);
      check("rst_flags", {pause, busy, cache_updated}, 64'b100);
      check("rst_state", fsm_state, IDLE);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      // Aligned core fill
      log_q.delete(); update_cache = 1'b1; point_pos = 32'd1;
      start_op();
      check("t1_state", fsm_state, CORE_RD);
      wait_for(1, n);
      check("t1_latency", 64'(n), 64'd4);
      check("t1_cache_x", cache_x, 64'h0003_0002_0001_0000);
      check("t1_cache_y", cache_y, 64'h0103_0102_0101_0100);
      check("t1_cache_z", cache_z, 64'h0203_0202_0201_0200);
      exp_log = '{0, 1}; check_log("t1_log");
      update_cache = 1'b0;
      @(negedge clock);
      check("t1_pulse_len", cache_updated, 1'b0);
      check("t1_to_feed", fsm_state, FEED_RD);
      stop_op();
      check("t1_idle", busy, 1'b0);

      // Misaligned core fill
      log_q.delete(); update_cache = 1'b1; point_pos = 32'd2;
      start_op();
      wait_for(1, n);
      check("t2_latency", 64'(n), 64'd5);
      check("t2_cache_x", cache_x, 64'h0004_0003_0002_0001);
      check("t2_cache_y", cache_y, 64'h0104_0103_0102_0101);
      exp_log = '{0, 1, 2}; check_log("t2_log");
      update_cache = 1'b0;
      stop_op();

      // Core near end of cloud
      log_q.delete(); point_cloud_size = 32'd5; update_cache = 1'b1; point_pos = 32'd4;
      start_op();
      wait_for(1, n);
      check("t3_latency", 64'(n), 64'd5);
      check("t3_cache_x", cache_x, 64'h0000_0000_0004_0003);
      check("t3_cache_z", cache_z, 64'h0000_0000_0204_0203);
      exp_log = '{1, 2, 3}; check_log("t3_log");
      update_cache = 1'b0;
      stop_op();

      // Feeder streaming with wrap-around
      log_q.delete();
      start_op();
      for (int b = 0; b < 4; b++) begin
         if (b > 0) @(negedge clock);
         wait_for(0, n);
         check("t4_batch_gap", 64'(n), 64'd3);
         check("t4_feeder_x", cache_feeder_x, exp_fx[b]);
         check("t4_feeder_y", cache_feeder_y, exp_fy[b]);
      end
      exp_log = '{0, 1, 2, 0}; check_log("t4_log");
      stop_op();
      check("t4_idle", busy, 1'b0);
      check("t4_feeder_hold", cache_feeder_x, 32'h0001_0000);

      // Core refill requested while a feeder batch is in flight
      log_q.delete(); point_pos = 32'd1;
      start_op();
      wait_for(0, n);
      check("t5_b1", cache_feeder_x, 32'h0001_0000);
      @(negedge clock);
      @(negedge clock);
      update_cache = 1'b1;
      wait_for(0, n);
      check("t5_b2_gap", 64'(n), 64'd2);
      check("t5_b2", cache_feeder_x, 32'h0003_0002);
      @(negedge clock);
      check("t5_core_state", fsm_state, CORE_RD);
      check("t5_feeder_hold", cache_feeder_x, 32'h0003_0002);
      wait_for(1, n);
      check("t5_core_latency", 64'(n), 64'd4);
      update_cache = 1'b0;
      check("t5_cache_x", cache_x, 64'h0003_0002_0001_0000);
      @(negedge clock);
      wait_for(0, n);
      check("t5_b3_gap", 64'(n), 64'd3);
      check("t5_b3", cache_feeder_x, 32'h0000_0004);
      exp_log = '{0, 1, 0, 1, 2}; check_log("t5_log");
      stop_op();

      // Asynchronous reset in the middle of a core fill
      point_cloud_size = 32'd8; update_cache = 1'b1; point_pos = 32'd1;
      start_op();
      @(negedge clock);
      check("t6_reading", bram_en, 1'b1);
      #2 reset = 1'b0;
      #1;
      check("t6_bram", {bram_en, bram_addr}, 64'h0);
      check("t6_flags", {pause, busy, cache_updated}, 64'b100);
      check("t6_feeder_x", cache_feeder_x, 64'h0);
      check("t6_cache_x", cache_x, 64'h0);
      check("t6_state", fsm_state, IDLE);
      @(negedge clock);
      reset = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         check("t6_stay_idle", {busy, cache_updated, bram_en}, 64'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
